// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 6502 cycle sequencer: addressing-mode codes,
// address-source encodings, T-state type and the supported-mode helper.
package cpu_sequencer_pkg;

   // Addressing-mode codes driven by the instruction decoder
   localparam logic [4:0] ADR_IMPL       = 5'd0;
   localparam logic [4:0] ADR_ACCUM      = 5'd1;
   localparam logic [4:0] ADR_IMM        = 5'd2;
   localparam logic [4:0] ADR_ZPG        = 5'd3;
   localparam logic [4:0] ADR_ZPG_RMW    = 5'd4;
   localparam logic [4:0] ADR_ZPG_X_Y    = 5'd5;
   localparam logic [4:0] ADR_ZPG_X_RMW  = 5'd6;
   localparam logic [4:0] ADR_ABS        = 5'd7;
   localparam logic [4:0] ADR_ABS_RMW    = 5'd8;
   localparam logic [4:0] ADR_ABS_JMP    = 5'd9;
   localparam logic [4:0] ADR_ABS_X_Y    = 5'd10;
   localparam logic [4:0] ADR_ABS_X_RMW  = 5'd11;
   localparam logic [4:0] ADR_REL        = 5'd12;
   localparam logic [4:0] ADR_STACK_PUSH = 5'd13;
   localparam logic [4:0] ADR_STACK_PULL = 5'd14;
   localparam logic [4:0] ADR_ABS_JSR    = 5'd15;
   localparam logic [4:0] ADR_ABS_IND    = 5'd16;
   localparam logic [4:0] ADR_ABS_X_IND  = 5'd17;
   localparam logic [4:0] ADR_ZPG_IND_Y  = 5'd18;
   localparam logic [4:0] ADR_INVAL      = 5'd31;

   // Address-source select encodings
   localparam logic [2:0] SEQ_SRC_PC      = 3'd0;
   localparam logic [2:0] SEQ_SRC_ZPG     = 3'd1;
   localparam logic [2:0] SEQ_SRC_ABS     = 3'd2;
   localparam logic [2:0] SEQ_SRC_IDX     = 3'd3;
   localparam logic [2:0] SEQ_SRC_IDX_FIX = 3'd4;

   // Longest instruction ends in T6
   localparam logic [2:0] SEQ_T_MAX = 3'd6;

   typedef enum logic [2:0] {
      TS0 = 3'd0, TS1 = 3'd1, TS2 = 3'd2, TS3 = 3'd3,
      TS4 = 3'd4, TS5 = 3'd5, TS6 = 3'd6
   } t_state_e;

   // Modes this sequencer can step; everything else halts at T1
   function automatic logic mode_supported(input logic [4:0] mode);
      logic ok;
      case (mode)
         ADR_IMPL, ADR_ACCUM, ADR_IMM, ADR_ZPG, ADR_ZPG_RMW, ADR_ZPG_X_Y,
         ADR_ZPG_X_RMW, ADR_ABS, ADR_ABS_RMW, ADR_ABS_JMP, ADR_ABS_X_Y,
         ADR_ABS_X_RMW, ADR_REL: ok = 1'b1;
         default:               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/cpu_sequencer_len.sv
// cpu_seq_len: combinational "last cycle of instruction" decode.
// T0 is never last; unsupported modes never finish (the top halts them).
module cpu_seq_len
   import cpu_sequencer_pkg::*;
(
   input  logic [4:0] adr_mode,
   input  logic       to_mem,
   input  logic       page_cross,
   input  logic       branch_taken,
   input  t_state_e   t_state,
   output logic       last
);

   // Per-mode final T-state, with the data-dependent ABS_X_Y and REL lengths
   always_comb begin
      last = 1'b0;
      case (adr_mode)
         ADR_IMPL, ADR_ACCUM, ADR_IMM: last = (t_state == TS1);
         ADR_ZPG:       last = (t_state == TS2);
         ADR_ZPG_RMW:   last = (t_state == TS4);
         ADR_ZPG_X_Y:   last = (t_state == TS3);
         ADR_ZPG_X_RMW: last = (t_state == TS5);
         ADR_ABS:       last = (t_state == TS3);
         ADR_ABS_RMW:   last = (t_state == TS5);
         ADR_ABS_JMP:   last = (t_state == TS2);
         // stores always take the high-byte fix cycle
         ADR_ABS_X_Y:   last = ((t_state == TS3) && !to_mem && !page_cross) ||
                               (t_state == TS4);
         ADR_ABS_X_RMW: last = (t_state == TS6);
         ADR_REL:       last = ((t_state == TS1) && !branch_taken) ||
                               ((t_state == TS2) && !page_cross) ||
                               (t_state == TS3);
         default:       last = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: T-state counter, halt flag, rdy stall gating and strobe
// decode for the 6502 core. Optional performance counters are built when
// the macro CPU_SEQ_PERF_EN is defined.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter bit RMW_DUMMY_WRITE = 1'b1
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   input  logic [4:0] adr_mode,
   input  logic       to_mem,
   input  logic       from_mem,
   input  logic       page_cross,
   input  logic       branch_taken,
   output logic       sync,
   output logic       ir_load,
   output logic       pc_inc,
   output logic [2:0] adr_src,
   output logic       we,
   output logic       exec,
   output logic [2:0] t_state,
   output logic       halted
`ifdef CPU_SEQ_PERF_EN
   ,
   output logic [31:0] cyc_cnt,
   output logic [31:0] instr_cnt
`endif
);

   t_state_e   t_state_r;
   t_state_e   t_next_s;
   logic       halted_r;
   logic       halted_next_s;
   logic       last_s;
   logic       unsupported_s;
   logic       frozen_s;
   logic       stall_s;
   logic       sync_s;
   logic       ir_load_s;
   logic       pc_inc_s;
   logic       we_raw_s;
   logic       exec_s;
   logic [2:0] adr_src_s;

   cpu_seq_len u_len (
      .adr_mode     (adr_mode),
      .to_mem       (to_mem),
      .page_cross   (page_cross),
      .branch_taken (branch_taken),
      .t_state      (t_state_r),
      .last         (last_s)
   );

   // adr_mode is only meaningful once the decoder sees the new IR (T1 on)
   assign unsupported_s = (t_state_r == TS1) && !mode_supported(adr_mode);
   assign frozen_s      = halted_r || unsupported_s;
   // Only read cycles wait for the bus
   assign stall_s       = !frozen_s && !we_raw_s && !rdy;

   // Raw strobe decode from the current T-state and addressing mode
   always_comb begin
      sync_s    = 1'b0;
      ir_load_s = 1'b0;
      pc_inc_s  = 1'b0;
      adr_src_s = SEQ_SRC_PC;
      we_raw_s  = 1'b0;
      exec_s    = 1'b0;
      if (frozen_s) begin
         adr_src_s = SEQ_SRC_PC;
      end else if (t_state_r == TS0) begin
         sync_s    = 1'b1;
         ir_load_s = 1'b1;
         pc_inc_s  = 1'b1;
      end else begin
         case (adr_mode)
            ADR_IMPL, ADR_ACCUM: exec_s = (t_state_r == TS1);
            ADR_IMM: begin
               pc_inc_s = (t_state_r == TS1);
               exec_s   = (t_state_r == TS1);
            end
            ADR_ZPG: begin
               case (t_state_r)
                  TS1: pc_inc_s = 1'b1;
                  TS2: begin adr_src_s = SEQ_SRC_ZPG; we_raw_s = to_mem; exec_s = from_mem; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ZPG_RMW: begin
               case (t_state_r)
                  TS1: pc_inc_s = 1'b1;
                  TS2: adr_src_s = SEQ_SRC_ZPG;
                  TS3: begin adr_src_s = SEQ_SRC_ZPG; we_raw_s = RMW_DUMMY_WRITE; end
                  TS4: begin adr_src_s = SEQ_SRC_ZPG; we_raw_s = 1'b1; exec_s = 1'b1; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ZPG_X_Y: begin
               case (t_state_r)
                  TS1: pc_inc_s = 1'b1;
                  TS2: adr_src_s = SEQ_SRC_ZPG;
                  TS3: begin adr_src_s = SEQ_SRC_IDX; we_raw_s = to_mem; exec_s = from_mem; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ZPG_X_RMW: begin
               case (t_state_r)
                  TS1: pc_inc_s = 1'b1;
                  TS2: adr_src_s = SEQ_SRC_ZPG;
                  TS3: adr_src_s = SEQ_SRC_IDX;
                  TS4: begin adr_src_s = SEQ_SRC_IDX; we_raw_s = RMW_DUMMY_WRITE; end
                  TS5: begin adr_src_s = SEQ_SRC_IDX; we_raw_s = 1'b1; exec_s = 1'b1; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ABS: begin
               case (t_state_r)
                  TS1, TS2: pc_inc_s = 1'b1;
                  TS3: begin adr_src_s = SEQ_SRC_ABS; we_raw_s = to_mem; exec_s = from_mem; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ABS_RMW: begin
               case (t_state_r)
                  TS1, TS2: pc_inc_s = 1'b1;
                  TS3: adr_src_s = SEQ_SRC_ABS;
                  TS4: begin adr_src_s = SEQ_SRC_ABS; we_raw_s = RMW_DUMMY_WRITE; end
                  TS5: begin adr_src_s = SEQ_SRC_ABS; we_raw_s = 1'b1; exec_s = 1'b1; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ABS_JMP: begin
               // exec in T2 loads PC from the address latch
               case (t_state_r)
                  TS1: pc_inc_s = 1'b1;
                  TS2: exec_s = 1'b1;
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ABS_X_Y: begin
               // T3 completes a read only when no carry into the high byte
               case (t_state_r)
                  TS1, TS2: pc_inc_s = 1'b1;
                  TS3: begin
                     adr_src_s = SEQ_SRC_IDX;
                     exec_s    = from_mem && !to_mem && !page_cross;
                  end
                  TS4: begin adr_src_s = SEQ_SRC_IDX_FIX; we_raw_s = to_mem; exec_s = from_mem; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_ABS_X_RMW: begin
               case (t_state_r)
                  TS1, TS2: pc_inc_s = 1'b1;
                  TS3: adr_src_s = SEQ_SRC_IDX;
                  TS4: adr_src_s = SEQ_SRC_IDX_FIX;
                  TS5: begin adr_src_s = SEQ_SRC_IDX_FIX; we_raw_s = RMW_DUMMY_WRITE; end
                  TS6: begin adr_src_s = SEQ_SRC_IDX_FIX; we_raw_s = 1'b1; exec_s = 1'b1; end
                  default: adr_src_s = SEQ_SRC_PC;
               endcase
            end
            ADR_REL: pc_inc_s = (t_state_r == TS1);
            default: adr_src_s = SEQ_SRC_PC;
         endcase
      end
   end

   // Stall gating on the commit strobes; reset suppresses any write
   assign sync    = sync_s;
   assign ir_load = ir_load_s && !stall_s;
   assign pc_inc  = pc_inc_s && !stall_s;
   assign exec    = exec_s && !stall_s;
   assign we      = we_raw_s && !rst;
   assign adr_src = adr_src_s;
   assign t_state = t_state_r;
   assign halted  = frozen_s;

   // Next T-state: freeze on halt, hold on stall, wrap to T0 after last cycle
   always_comb begin
      t_next_s      = t_state_r;
      halted_next_s = halted_r;
      if (frozen_s) begin
         halted_next_s = 1'b1;
         t_next_s      = t_state_r;
      end else if (stall_s) begin
         t_next_s = t_state_r;
      end else if (last_s || (t_state_r == SEQ_T_MAX)) begin
         t_next_s = TS0;
      end else begin
         t_next_s = t_state_e'(t_state_r + 3'd1);
      end
   end

   // State register with synchronous reset to an opcode fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         t_state_r <= TS0;
         halted_r  <= 1'b0;
      end else begin
         t_state_r <= t_next_s;
         halted_r  <= halted_next_s;
      end
   end

`ifdef CPU_SEQ_PERF_EN
   logic [31:0] cyc_cnt_r;
   logic [31:0] instr_cnt_r;

   // Active-cycle and instruction counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt_r   <= 32'd0;
         instr_cnt_r <= 32'd0;
      end else begin
         if (!frozen_s && (rdy || we)) begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
         end else begin
            cyc_cnt_r <= cyc_cnt_r;
         end
         if (sync && rdy) begin
            instr_cnt_r <= instr_cnt_r + 32'd1;
         end else begin
            instr_cnt_r <= instr_cnt_r;
         end
      end
   end

   assign cyc_cnt   = cyc_cnt_r;
   assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Cycle sequencer for the 6502 core.
- Consumes the addressing mode and memory-direction bits produced by the instruction decoder.
- Steps T-states per instruction and drives opcode fetch, PC increment, address-source select, memory write enable and the ALU/register execute strobe.
- Sits between the decoder, the address datapath (PC, address latch, index adder) and the external bus.

Parameters:
- RMW_DUMMY_WRITE, 1, when 1 the RMW modify cycle re-writes the unmodified operand (NMOS behaviour); when 0 that cycle is a bus idle read.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  bus ready; low stalls read cycles only
- adr_mode  in  5  addressing mode from decoder, `ADR_* codes from config.vh
- to_mem  in  1  instruction stores register to memory (decoder)
- from_mem  in  1  instruction reads operand from memory (decoder)
- page_cross  in  1  carry out of index/branch low-byte add in the current cycle
- branch_taken  in  1  branch condition true (flag test result)
- sync  out  1  opcode fetch cycle (T0)
- ir_load  out  1  latch data bus into IR this cycle
- pc_inc  out  1  increment PC at end of cycle
- adr_src  out  3  0=PC, 1=zero-page latch, 2=absolute latch, 3=indexed latch, 4=indexed latch high-byte fix
- we  out  1  memory write this cycle
- exec  out  1  commit ALU/register result and flags at end of cycle
- t_state  out  3  current cycle index within the instruction (0..6)
- halted  out  1  invalid or unsupported mode reached; sequencer frozen

Behaviour:
- All outputs are registered-state decodes. Reset values: t_state=0, sync=1, ir_load=1, pc_inc=1, adr_src=0, we=0, exec=0, halted=0. The first cycle after reset is an opcode fetch.
- T0 (fetch): sync=1, ir_load=1, pc_inc=1, adr_src=PC. adr_mode is sampled from T1 on, since the decoder sees the new IR.
- Cycle counts, total including T0:
  - IMPL/ACCUM 2 (exec in T1, no pc_inc)
  - IMM 2 (pc_inc+exec in T1)
  - ZPG 3
  - ZPG_RMW 5
  - ZPG_X_Y 4
  - ZPG_X_RMW 6
  - ABS 4
  - ABS_RMW 6
  - ABS_JMP 3 (PC load in T2)
  - ABS_X_Y: 4 for reads, +1 when page_cross is sampled in T3; stores always 5
  - ABS_X_RMW 7
  - REL: 2 if not taken, 3 if taken without page cross, 4 if taken with page cross
- Operand cycle: we=to_mem, exec=from_mem. In the operand cycle of an RMW mode, adr_src holds and the cycles are read, modify (we=RMW_DUMMY_WRITE), then write (we=1, exec=1).
- Zero-page indexed addresses wrap within page 0. page_cross is ignored for ZPG_X_Y.
- rdy=0 during a read cycle:
  - t_state holds
  - ir_load, pc_inc and exec are forced 0
  - adr_src holds
- rdy is ignored on cycles with we=1.
- Last cycle of every instruction transitions to T0 of the next. No overlap/pipelined fetch.
- Unsupported modes (STACK_*, ABS_JSR, ABS_IND, ABS_X_IND, ZPG_IND_Y, INVAL) reached at T1: halted=1 and all strobes 0. Only rst clears this state.
- rst asserted mid-instruction aborts immediately. No write completes in the reset cycle (we=0).
- Simultaneous page_cross and rdy=0 in T3 of ABS_X_Y: the stall wins. page_cross is re-sampled when rdy rises.

Optional Feature:
- Macro CPU_SEQ_PERF_EN.
- When defined, adds outputs cyc_cnt[31:0] and instr_cnt[31:0]:
  - cyc_cnt increments every non-halted cycle with rdy=1 or we=1.
  - instr_cnt increments on each sync cycle with rdy=1.
  - Both clear on rst and wrap modulo 2^32.
- When undefined, the ports and counters are absent. Sequencing behaviour is identical in both cases.

Decomposition:
- Add the adr_src encodings (`SEQ_SRC_PC, `SEQ_SRC_ZPG, `SEQ_SRC_ABS, `SEQ_SRC_IDX, `SEQ_SRC_IDX_FIX) and the max t_state constant to config.vh beside the existing `ADR_* codes.
- One natural sub-module, cpu_seq_len: purely combinational. Maps adr_mode, to_mem, page_cross and branch_taken to a "last cycle" flag for the current t_state. The top module holds the counter, halt flag, rdy gating and strobe decode.

Test Plan:
- Release rst, feed IMM (LDA #$42 flow, from_mem=1) -> cycle 0 sync=1/ir_load=1/pc_inc=1; cycle 1 exec=1, pc_inc=1, we=0; cycle 2 sync=1.
- ABS_X_Y read with page_cross=1 at T3 -> 5 cycles, adr_src=3 at T3, adr_src=4 and exec=1 at T4. Same mode with to_mem=1 and page_cross=0 -> 5 cycles, we=1 only at T4.
- ZPG_RMW with RMW_DUMMY_WRITE=1 -> we pattern T0..T4 = 0,0,0,1,1, exec=1 only at T4. With RMW_DUMMY_WRITE=0 -> 0,0,0,0,1.
- REL with branch_taken 0/1 and page_cross 0/1 -> lengths 2, 3 and 4 cycles respectively.
- ZPG read, rdy=0 for 3 cycles at T2 -> t_state stays 2 and exec stays 0 for those cycles; exec=1 on the first cycle with rdy=1. Store at T2 with rdy=0 -> we=1 and advances.
- adr_mode=INVAL at T1 -> halted=1 and strobes 0 for 10 cycles; rst for 1 cycle -> sync=1, halted=0. With CPU_SEQ_PERF_EN, 3 IMPL instructions -> instr_cnt=3, cyc_cnt=6.
